// File: rtl/ct_mat_cmplt_arbiter_if.sv
// Completion bus between the matrix execution units and the pipe8 completion arbiter.
interface ct_mat_cmplt_arbiter_if #(
    parameter int unsigned IID_W = 7
);
    logic             rtu_yy_xx_flush;
    logic             mat_cfg_cbus_ex1_pipe8_sel;
    logic [IID_W-1:0] mat_cfg_cbus_ex1_pipe8_iid;
    logic             mat_alu_cbus_ex1_pipe8_sel;
    logic [IID_W-1:0] mat_alu_cbus_ex1_pipe8_iid;
    logic             mat_lsu_cbus_ex1_pipe8_sel;
    logic [IID_W-1:0] mat_lsu_cbus_ex1_pipe8_iid;
    logic             mat_arb_cfg_full;
    logic             mat_arb_alu_full;
    logic             mat_arb_lsu_full;
    logic             mat_rtu_pipe8_cmplt;
    logic [IID_W-1:0] mat_rtu_pipe8_iid;
    logic             mat_arb_idle;
    logic             mat_arb_ovfl;

    // Unit / flush side: issues completions, observes status.
    modport master (
        output rtu_yy_xx_flush,
        output mat_cfg_cbus_ex1_pipe8_sel, mat_cfg_cbus_ex1_pipe8_iid,
        output mat_alu_cbus_ex1_pipe8_sel, mat_alu_cbus_ex1_pipe8_iid,
        output mat_lsu_cbus_ex1_pipe8_sel, mat_lsu_cbus_ex1_pipe8_iid,
        input  mat_arb_cfg_full, mat_arb_alu_full, mat_arb_lsu_full,
        input  mat_rtu_pipe8_cmplt, mat_rtu_pipe8_iid,
        input  mat_arb_idle, mat_arb_ovfl
    );

    // Arbiter side.
    modport slave (
        input  rtu_yy_xx_flush,
        input  mat_cfg_cbus_ex1_pipe8_sel, mat_cfg_cbus_ex1_pipe8_iid,
        input  mat_alu_cbus_ex1_pipe8_sel, mat_alu_cbus_ex1_pipe8_iid,
        input  mat_lsu_cbus_ex1_pipe8_sel, mat_lsu_cbus_ex1_pipe8_iid,
        output mat_arb_cfg_full, mat_arb_alu_full, mat_arb_lsu_full,
        output mat_rtu_pipe8_cmplt, mat_rtu_pipe8_iid,
        output mat_arb_idle, mat_arb_ovfl
    );
endinterface

// File: rtl/ct_mat_cmplt_arbiter.sv
// Pipe8 completion arbiter: per-unit completion FIFOs drained round-robin,
// one registered completion per cycle to the RTU.
module ct_mat_cmplt_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IID_W = 7
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,
    ct_mat_cmplt_arbiter_if.slave  bus
);
    localparam int unsigned NSRC  = 3;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [IID_W-1:0] mem    [NSRC][DEPTH];
    logic [PTR_W-1:0] rd_ptr [NSRC];
    logic [PTR_W-1:0] wr_ptr [NSRC];
    logic [CNT_W-1:0] cnt    [NSRC];
    logic [IID_W-1:0] push_iid [NSRC];

    logic [NSRC-1:0]  sel;
    logic [NSRC-1:0]  full;
    logic [NSRC-1:0]  nonempty;
    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;

    logic [1:0]       rr_ptr;
    logic [2:0]       cand;
    logic             gnt_vld;
    logic [1:0]       gnt_idx;
    logic [IID_W-1:0] gnt_iid;

    logic             cmplt_q;
    logic [IID_W-1:0] iid_q;
    logic             ovfl_q;

    // Gather the three unit push ports into indexable form (cfg=0, alu=1, lsu=2).
    always_comb begin
        sel         = '0;
        sel[0]      = bus.mat_cfg_cbus_ex1_pipe8_sel;
        sel[1]      = bus.mat_alu_cbus_ex1_pipe8_sel;
        sel[2]      = bus.mat_lsu_cbus_ex1_pipe8_sel;
        push_iid[0] = bus.mat_cfg_cbus_ex1_pipe8_iid;
        push_iid[1] = bus.mat_alu_cbus_ex1_pipe8_iid;
        push_iid[2] = bus.mat_lsu_cbus_ex1_pipe8_iid;
    end

    // FIFO status and accepted pushes; a flush drops same-cycle pushes.
    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int s = 0; s < NSRC; s++) begin
            full[s]     = (cnt[s] == CNT_W'(DEPTH));
            nonempty[s] = (cnt[s] != '0);
            push[s]     = sel[s] && !full[s] && !bus.rtu_yy_xx_flush;
        end
    end

    // Round-robin grant: first non-empty source at or after rr_ptr; none during flush.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        pop     = '0;
        for (int k = 0; k < NSRC; k++) begin
            cand = 3'(rr_ptr) + 3'(k);
            if (cand >= 3'(NSRC)) begin
                cand = cand - 3'(NSRC);
            end
            if (!gnt_vld && nonempty[cand[1:0]] && !bus.rtu_yy_xx_flush) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[1:0];
            end
        end
        if (gnt_vld) begin
            pop[gnt_idx] = 1'b1;
        end
        gnt_iid = mem[gnt_idx][rd_ptr[gnt_idx]];
    end

    // FIFO storage; contents need no reset since counts gate visibility.
    always_ff @(posedge forever_cpuclk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push[s] && !cpurst) begin
                mem[s][wr_ptr[s]] <= push_iid[s];
            end
        end
    end

    // Pointers, counts, round-robin state, sticky overflow and output register.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            for (int s = 0; s < NSRC; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            rr_ptr  <= '0;
            cmplt_q <= 1'b0;
            iid_q   <= '0;
            ovfl_q  <= 1'b0;
        end else if (bus.rtu_yy_xx_flush) begin
            for (int s = 0; s < NSRC; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            cmplt_q <= 1'b0;
            iid_q   <= '0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                if (push[s]) begin
                    wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                end
                if (pop[s]) begin
                    rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                end
                if (push[s] && !pop[s]) begin
                    cnt[s] <= cnt[s] + CNT_W'(1);
                end else if (!push[s] && pop[s]) begin
                    cnt[s] <= cnt[s] - CNT_W'(1);
                end
            end
            if ((sel & full) != '0) begin
                ovfl_q <= 1'b1;
            end
            cmplt_q <= gnt_vld;
            iid_q   <= gnt_vld ? gnt_iid : '0;
            if (gnt_vld) begin
                rr_ptr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            end
        end
    end

    // Status outputs: full/idle derive from the registered counts and output.
    always_comb begin
        bus.mat_arb_cfg_full    = full[0];
        bus.mat_arb_alu_full    = full[1];
        bus.mat_arb_lsu_full    = full[2];
        bus.mat_rtu_pipe8_cmplt = cmplt_q;
        bus.mat_rtu_pipe8_iid   = iid_q;
        bus.mat_arb_idle        = (nonempty == '0) && !cmplt_q;
        bus.mat_arb_ovfl        = ovfl_q;
    end

endmodule

// File: doc/ct_mat_cmplt_arbiter.md
# ct_mat_cmplt_arbiter

Completion arbiter for matrix pipe8. It sits between the three matrix execution units (config, arithmetic, load/store) and the RTU completion port, which accepts one completion per cycle. Each unit's ex1 completion pulses are buffered in a per-source FIFO. A round-robin arbiter drains the FIFOs and issues exactly one registered `mat_rtu_pipe8_cmplt`/`iid` per cycle, so simultaneous completions from different units are never merged or lost.

## Interface
Parameters:
- `DEPTH`, 4 — entries per source FIFO; power of two, ≥2.
- `IID_W`, 7 — instruction ID width.

Ports:
- `forever_cpuclk` in 1 — the single clock.
- `cpurst` in 1 — reset; synchronous, active-high.
- `rtu_yy_xx_flush` in 1 — pipeline flush; synchronous.
- `mat_cfg_cbus_ex1_pipe8_sel` in 1 — config-unit completion push.
- `mat_cfg_cbus_ex1_pipe8_iid` in IID_W — IID for that push.
- `mat_alu_cbus_ex1_pipe8_sel` in 1 — arithmetic-unit completion push.
- `mat_alu_cbus_ex1_pipe8_iid` in IID_W — IID for that push.
- `mat_lsu_cbus_ex1_pipe8_sel` in 1 — ldst-unit completion push.
- `mat_lsu_cbus_ex1_pipe8_iid` in IID_W — IID for that push.
- `mat_arb_cfg_full` out 1 — config FIFO holds DEPTH entries.
- `mat_arb_alu_full` out 1 — arithmetic FIFO holds DEPTH entries.
- `mat_arb_lsu_full` out 1 — ldst FIFO holds DEPTH entries.
- `mat_rtu_pipe8_cmplt` out 1 — registered completion pulse to RTU.
- `mat_rtu_pipe8_iid` out IID_W — registered IID; valid when cmplt=1, and 0 when cmplt=0.
- `mat_arb_idle` out 1 — all FIFOs empty and cmplt=0.
- `mat_arb_ovfl` out 1 — sticky error: a push arrived while that FIFO was full.

## Operation
- Each source has its own FIFO: DEPTH entries of IID_W bits, with rd/wr pointers that wrap modulo DEPTH and a count of width clog2(DEPTH+1).
- **Push:** `sel`=1 and count<DEPTH writes the IID at wr_ptr.
- **Push while full:** `sel`=1 and count==DEPTH drops the push and sets `mat_arb_ovfl`.
- **Full flags:** `*_full` = (count==DEPTH), combinational from the count register. A pop in the same cycle does not clear full for that cycle. Sources must not push while full.
- **Arbitration:** each cycle, among non-empty FIFOs, grant the first at or after `rr_ptr` in the order cfg(0) → alu(1) → lsu(2) → cfg.
  - On a grant, pop that FIFO, load its head IID into the output register, and set `rr_ptr` = granted+1 (mod 3).
  - With no grant, the output register clears (cmplt=0, iid=0) and `rr_ptr` holds.
- **Same-cycle push and pop** on one FIFO: both occur, count is unchanged, and IID order is preserved.
- **Empty-FIFO push:** the entry becomes visible next cycle. There is no bypass.
- **Flush** (`rtu_yy_xx_flush`=1):
  - Next cycle: all FIFOs are empty (pointers and counts 0) and cmplt=0, iid=0.
  - Pushes in the flush cycle are dropped, with no ovfl.
  - No grant is made in the flush cycle.
  - `rr_ptr` and `mat_arb_ovfl` hold.
- **Reset** (`cpurst`=1): all FIFOs empty, `rr_ptr`=cfg, cmplt=0, iid=0, ovfl=0, full=0, idle=1. Reset overrides flush and push.

## Timing
- **Latency:** `sel` sampled at edge of cycle N → entry in FIFO in cycle N+1 → granted in N+1 → `mat_rtu_pipe8_cmplt`=1 in cycle N+2. The minimum is 2 cycles.
- **Throughput:** exactly 1 completion per cycle while any FIFO is non-empty, and never 2.
- **Pulse width:** each accepted push yields exactly one 1-cycle cmplt pulse, unless it is discarded by flush or reset.
- **Fairness:** with k sources continuously non-empty, each is granted once every k cycles.
- **Mid-operation reset or flush:** outputs take reset/flush values on the cycle after assertion, and pending entries are discarded.

## Test plan
- **Single push:** after reset, cfg push iid=0x05 in cycle 1 → cmplt=1, iid=0x05 in cycle 3 only; idle=1 from cycle 4.
- **Simultaneous push:** cfg/alu/lsu push 0x10/0x20/0x30 in the same cycle 1 → cmplt in cycles 3, 4, 5 with iid 0x10, 0x20, 0x30; rr_ptr ends at cfg.
- **Round-robin fairness:** alu and lsu each push every cycle for 6 cycles (iids incrementing from 0x40 and 0x60), cfg idle → outputs alternate alu, lsu, alu…; per-source order preserved; no ovfl.
- **Full and overflow:** with DEPTH=4, all three push every cycle.
  - `*_full` rises once a count hits 4.
  - One further push on a full FIFO → ovfl=1, that IID never appears, ovfl stays 1 through a later flush.
- **Flush mid-drain:** 3 entries queued, flush asserted together with an lsu push 0x7F → next cycle cmplt=0, idle=1, and 0x7F never issued.
- **Reset mid-drain:** cpurst asserted with entries pending and ovfl=1 → next cycle all outputs 0, idle=1; a cfg push afterwards completes with 2-cycle latency.
